// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Holds one word per line and serves CPU loads and stores against a simple request/ack memory port.
module data_cache_ctrl #(
  parameter int LINES = 16,
  parameter int WD    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WD-1:0] Ad,
  input  logic [WD-1:0] DIn,
  input  logic          RamRead,
  input  logic          RamWrite,
  input  logic [2:0]    func3,
  output logic [WD-1:0] DOut,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [WD-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [WD-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int IW = $clog2(LINES);
  localparam int TW = WD - IW - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] WDONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [WD-1:0]    data_q [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;

  assign idx = Ad[IW+1:2];
  assign tag = Ad[WD-1:IW+2];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Store lane placement: data is replicated across lanes, strobes pick the live ones.
  logic [3:0]    lane_strb;
  logic [WD-1:0] lane_data;
  logic [WD-1:0] lane_mask;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_strb = 4'b1111;
    lane_data = DIn;
    case (func3[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << Ad[1:0];
        lane_data = {4{DIn[7:0]}};
      end
      2'b01: begin
        lane_strb = Ad[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{DIn[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = DIn;
      end
    endcase
  end

  assign lane_mask = {{8{lane_strb[3]}}, {8{lane_strb[2]}},
                      {8{lane_strb[1]}}, {8{lane_strb[0]}}};

  assign mem_addr  = {Ad[WD-1:2], 2'b00};
  assign mem_wdata = lane_data;

  // Load extraction from the indexed line.
  logic [WD-1:0] rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  always_comb begin
    rd_word = data_q[idx];
    rd_half = Ad[1] ? rd_word[31:16] : rd_word[15:0];
    case (Ad[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (func3)
      3'b000:  DOut = {{(WD-8){rd_byte[7]}}, rd_byte};
      3'b001:  DOut = {{(WD-16){rd_half[15]}}, rd_half};
      3'b100:  DOut = {{(WD-8){1'b0}}, rd_byte};
      3'b101:  DOut = {{(WD-16){1'b0}}, rd_half};
      default: DOut = rd_word;
    endcase
  end

  logic          stall_c;
  logic          arr_we;
  logic [WD-1:0] arr_wdata;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    arr_we    = 1'b0;
    arr_wdata = mem_rdata;
    stall_c   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    case (state_q)
      IDLE: begin
        // A simultaneous read and write request is handled as a write.
        if (RamWrite) begin
          stall_c = 1'b1;
          state_d = WRITE;
        end else if (RamRead && !hit) begin
          stall_c = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall_c = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          arr_we       = 1'b1;
          arr_wdata    = mem_rdata;
          valid_d[idx] = 1'b1;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        stall_c   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wstrb = lane_strb;
        if (mem_ack) begin
          if (hit) begin
            arr_we    = 1'b1;
            arr_wdata = (rd_word & ~lane_mask) | (lane_data & lane_mask);
          end
          state_d = WDONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any pending request, so the CPU is released while it is held.
  assign stall = stall_c & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone make their contents meaningful.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= arr_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: a CPU driver, a fixed-latency memory model,
// and scoreboards for load results and memory writes.
module tb_data_cache_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Ad, DIn, DOut;
  logic        RamRead, RamWrite;
  logic [2:0]  func3;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        mem_ack_m = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] stray_rdata = 32'h0;

  assign mem_ack   = mem_ack_m | stray_ack;
  assign mem_rdata = stray_ack ? stray_rdata : model_rdata;

  always #5 clk = ~clk;

  data_cache_ctrl #(.LINES(16), .WD(32)) dut (
    .clk(clk), .reset(reset), .Ad(Ad), .DIn(DIn),
    .RamRead(RamRead), .RamWrite(RamWrite), .func3(func3),
    .DOut(DOut), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic [31:0] load_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  txn_cnt = 0;
  int  req_cycles = 0;
  bit  mem_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Memory model: acks on the LAT-th cycle of a request, checks writes against wr_q.
  always @(negedge clk) begin
    wr_t w;
    logic [31:0] m;
    logic [31:0] old;
    mem_ack_m = 1'b0;
    if (mem_req === 1'b1 && mem_en) begin
      req_cycles++;
      if (req_cycles == LAT) begin
        req_cycles = 0;
        mem_ack_m  = 1'b1;
        txn_cnt++;
        if (mem_we) begin
          check("write expected", 32'(wr_q.size() != 0), 32'd1);
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            m = strb_mask(w.strb);
            check("write addr", mem_addr, w.addr);
            check("write strb", 32'(mem_wstrb), 32'(w.strb));
            check("write data", mem_wdata & m, w.data & m);
          end
          m   = strb_mask(mem_wstrb);
          old = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          mem_model[mem_addr] = (old & ~m) | (mem_wdata & m);
        end else begin
          model_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end
      end
    end else begin
      req_cycles = 0;
    end
  end

  // One CPU access: inputs held until stall drops, then the result is scored.
  task automatic cpu_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                        input logic [31:0] exp_data, input logic [3:0] exp_strb,
                        input int exp_stalls, input int exp_txn);
    int stalls = 0;
    int t0;
    @(negedge clk);
    RamRead = rd; RamWrite = wr; Ad = a; DIn = d; func3 = f3;
    t0 = txn_cnt;
    if (wr) wr_q.push_back('{addr: {a[31:2], 2'b00}, data: exp_data, strb: exp_strb});
    else    load_q.push_back(exp_data);
    #1;
    while (stall !== 1'b0 && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    check({tag, " mem txns"}, 32'(txn_cnt - t0), 32'(exp_txn));
    if (!wr) begin
      check({tag, " load pending"}, 32'(load_q.size() != 0), 32'd1);
      if (load_q.size() != 0) check({tag, " DOut"}, DOut, load_q.pop_front());
    end
  endtask

  initial begin
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0080] = 32'h0000_80F0;
    mem_model[32'h0000_0044] = 32'h1111_1111;
    mem_model[32'h0000_1040] = 32'h1234_5678;
    mem_model[32'h0000_2040] = 32'hA5A5_A5A5;

    reset = 1'b1; RamRead = 1'b0; RamWrite = 1'b0;
    Ad = 32'h0; DIn = 32'h0; func3 = 3'b010;
    #2;
    check("reset stall", 32'(stall), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    cpu_op("cold LW 0x40",  1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_BEEF, 4'h0, 4, 1);
    cpu_op("hit LW 0x40",   1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_BEEF, 4'h0, 0, 0);
    cpu_op("SB 0x41",       0, 1, 32'h41, 32'hAA, 3'b000, 32'h0000_AA00, 4'b0010, 4, 1);
    cpu_op("merged LW 0x40",1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_AAEF, 4'h0, 0, 0);
    cpu_op("LB 0x80",       1, 0, 32'h80, 32'h0, 3'b000, 32'hFFFF_FFF0, 4'h0, 4, 1);
    cpu_op("LBU 0x80",      1, 0, 32'h80, 32'h0, 3'b100, 32'h0000_00F0, 4'h0, 0, 0);
    cpu_op("LH 0x82",       1, 0, 32'h82, 32'h0, 3'b001, 32'h0000_0000, 4'h0, 0, 0);
    cpu_op("LH 0x80",       1, 0, 32'h80, 32'h0, 3'b001, 32'hFFFF_80F0, 4'h0, 0, 0);
    cpu_op("LHU 0x80",      1, 0, 32'h80, 32'h0, 3'b101, 32'h0000_80F0, 4'h0, 0, 0);
    cpu_op("LB 0x81",       1, 0, 32'h81, 32'h0, 3'b000, 32'hFFFF_FF80, 4'h0, 0, 0);
    cpu_op("SW miss 0x1000",0, 1, 32'h1000, 32'hCAFE_F00D, 3'b010, 32'hCAFE_F00D, 4'b1111, 4, 1);
    cpu_op("LW 0x80 kept",  1, 0, 32'h80, 32'h0, 3'b010, 32'h0000_80F0, 4'h0, 0, 0);
    cpu_op("LW 0x1000",     1, 0, 32'h1000, 32'h0, 3'b010, 32'hCAFE_F00D, 4'h0, 4, 1);
    cpu_op("LW 0x1040",     1, 0, 32'h1040, 32'h0, 3'b010, 32'h1234_5678, 4'h0, 4, 1);
    cpu_op("LW 0x40 evict", 1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_AAEF, 4'h0, 4, 1);
    cpu_op("RW SH 0x46",    1, 1, 32'h46, 32'h0000_BEEF, 3'b001, 32'hBEEF_0000, 4'b1100, 4, 1);
    cpu_op("LW 0x44",       1, 0, 32'h44, 32'h0, 3'b010, 32'hBEEF_1111, 4'h0, 4, 1);
    cpu_op("SH hit 0x44",   0, 1, 32'h44, 32'h0000_1234, 3'b001, 32'h0000_1234, 4'b0011, 4, 1);
    cpu_op("LW 0x44 merged",1, 0, 32'h44, 32'h0, 3'b010, 32'hBEEF_1234, 4'h0, 0, 0);

    // Reset in the middle of a refill, followed by a stray ack while idle.
    mem_en = 1'b0;
    @(negedge clk);
    RamRead = 1'b1; RamWrite = 1'b0; Ad = 32'h2040; func3 = 3'b010;
    #1 check("abort miss stall", 32'(stall), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 check("abort refill mem_req", 32'(mem_req), 32'd1);
    #1 reset = 1'b1;
    #1 check("abort mem_req", 32'(mem_req), 32'd0);
    check("abort stall", 32'(stall), 32'd0);
    @(negedge clk);
    RamRead = 1'b0;
    reset = 1'b0;
    stray_rdata = 32'hBAD0_BAD0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1 check("stray ack ignored mem_req", 32'(mem_req), 32'd0);
    mem_en = 1'b1;

    cpu_op("LW 0x2040 after abort", 1, 0, 32'h2040, 32'h0, 3'b010, 32'hA5A5_A5A5, 4'h0, 4, 1);
    cpu_op("LW 0x40 after reset",   1, 0, 32'h40, 32'h0, 3'b010, 32'hDEAD_AAEF, 4'h0, 4, 1);

    @(negedge clk);
    RamRead = 1'b0; RamWrite = 1'b0;
    check("write queue drained", 32'(wr_q.size()), 32'd0);
    check("load queue drained", 32'(load_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, one 32-bit word per line).
REQ-002 Parameter WD, default 32, data/address width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 Ad  in  WD  CPU byte address (ALU result).
REQ-006 DIn  in  WD  CPU store data (rs2).
REQ-007 RamRead  in  1  CPU load request.
REQ-008 RamWrite  in  1  CPU store request.
REQ-009 func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 DOut  out  WD  load data, extended per func3.
REQ-011 stall  out  1  CPU must hold PC and all inputs while high.
REQ-012 mem_req  out  1  main-memory request valid.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  WD  word-aligned address {Ad[WD-1:2],2'b00}.
REQ-015 mem_wdata  out  WD  store data placed in its byte lanes.
REQ-016 mem_wstrb  out  4  byte-lane enables for writes; 0000 on reads.
REQ-017 mem_rdata  in  WD  memory read word, valid with mem_ack.
REQ-018 mem_ack  in  1  one-cycle completion pulse from memory.

Function
REQ-019 Index = Ad[log2(LINES)+1:2]; tag = Ad[WD-1:log2(LINES)+2]; per line SHALL store valid bit, tag, data word.
REQ-020 FSM states SHALL be IDLE, REFILL, WRITE, WDONE.
REQ-021 hit SHALL be valid[index] & (tag match), combinational.
REQ-022 IDLE, RamRead & hit (RamWrite=0): stall=0, DOut valid same cycle, no memory traffic, stay IDLE.
REQ-023 IDLE, RamRead & miss: stall=1 combinationally; next state REFILL.
REQ-024 REFILL: mem_req=1, mem_we=0, mem_wstrb=0000; stall=1; on mem_ack write line {valid=1, tag, mem_rdata}, go IDLE; load then hits (miss penalty = memory latency + 1 cycle).
REQ-025 IDLE, RamWrite: stall=1; next state WRITE (write-through, no write-allocate).
REQ-026 WRITE: mem_req=1, mem_we=1, strobes/lanes per func3 and Ad[1:0] (B: 1 lane, H: lanes Ad[1]*2..+1, W: 1111); stall=1; on mem_ack, if hit, merge strobed bytes into line; go WDONE.
REQ-027 WDONE: stall=0 for exactly one cycle so CPU retires the store; no memory request; next IDLE.
REQ-028 RamRead & RamWrite both high SHALL be treated as a write.
REQ-029 Neither request high: stall=0, state stays IDLE, DOut don't-care.
REQ-030 Load extraction: B/BU select byte Ad[1:0], H/HU select half Ad[1]; B/H sign-extend, BU/HU zero-extend, W whole word; misaligned low bits ignored beyond the selected lane.
REQ-031 mem_req SHALL stay high and mem_addr/mem_we/mem_wdata/mem_wstrb stable from request entry until the mem_ack cycle inclusive.
REQ-032 mem_ack outside REFILL/WRITE SHALL be ignored.
REQ-033 Inputs changing while stall=1 is a CPU protocol violation; behaviour unspecified.

Reset
REQ-034 reset SHALL asynchronously clear all valid bits, force IDLE, mem_req=0, mem_we=0, mem_wstrb=0000, stall=0 (no request pending).
REQ-035 Reset asserted during REFILL/WRITE SHALL abort the transaction immediately; line contents unchanged; a late mem_ack after reset is ignored.
REQ-036 Tag/data arrays need not be reset.

Verification
REQ-037 Cold load: reset, RamRead, Ad=0x40, func3=010, memory acks after 3 cycles with 0xDEADBEEF -> stall high 4 cycles, then DOut=0xDEADBEEF, stall=0, single mem_req burst.
REQ-038 Hit: repeat load Ad=0x40 -> stall=0 same cycle, DOut=0xDEADBEEF, mem_req stays 0.
REQ-039 Sign extension: line 0x80 holds 0x0000_80F0; LB Ad=0x80 -> 0xFFFFFFF0; LBU -> 0x000000F0; LH Ad=0x82 -> 0x00000000; LH Ad=0x80 -> 0xFFFF80F0.
REQ-040 Store hit: SB Ad=0x41 DIn=0x000000AA after REQ-037 -> mem_wstrb=0010, mem_wdata[15:8]=0xAA, one-cycle stall=0 in WDONE, subsequent LW Ad=0x40 hits with 0xDEADAAEF.
REQ-041 Conflict/no-allocate: SW to miss Ad=0x1000 -> memory write, no line install; LW Ad=0x1040 (same index as 0x40) -> miss, refill evicts 0x40; LW 0x40 then misses.
REQ-042 Reset mid-refill: reset during REFILL before mem_ack -> mem_req=0 immediately, stall=0, later ack ignored, next load of same address misses.
